// File: rtl/spm_pkg.sv
// Shared definitions for the bit-serial signed multiplier sequencer.
//   SPM_N / SPM_PW : operand width and product width
//   S_*            : sequencer state encoding
//   spm_cnt_w()    : width of a counter that spans a given number of steps
package spm_pkg;

   localparam int SPM_N  = 8;
   localparam int SPM_PW = 2 * SPM_N;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   function automatic int spm_cnt_w(input int steps);
      return (steps <= 2) ? 1 : $clog2(steps);
   endfunction

endpackage

// File: rtl/spm_deser.sv
// Right-shift collect register: each enabled cycle din enters the MSB, so
// after W shifts the first bit received sits in q[0].
//   clk, rst   : clock, async active-low reset (clears q)
//   shift_en   : shift one bit in this cycle
//   din        : serial input bit
//   q          : parallel contents
module spm_deser #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_en,
   input  logic         din,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {din, q[W-1:1]};
      end
   end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the bit-serial signed multiplier array. Captures an operand
// pair on start, holds the multiplicand on the array, streams the multiplier
// LSB first (sign-extended to 2N bits) and gathers the serial product.
//   clk, rst      : clock, async active-low reset
//   start         : request, honoured in IDLE or DONE only
//   multiplicand  : operand A, captured on acceptance
//   multiplier    : operand B, captured on acceptance
//   busy          : high in CLEAR and SHIFT
//   done          : one-cycle pulse, product valid from this cycle
//   product       : signed A*B, held until the next DONE
//   arr_mcand     : captured multiplicand to the array
//   arr_xbit      : serial multiplier bit to the array
//   arr_clr       : clear of the array's carry/sum flops
//   arr_pbit      : serial product bit from the array, LSB first
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | one cycle clearing the array
// SHIFT   | 2N cycles streaming multiplier bits and collecting product bits
// DONE    | result presented, done pulse; start here chains the next operation
module spm_seq_ctrl
   import spm_pkg::*;
#(
   parameter int N = SPM_N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     multiplicand,
   input  logic [N-1:0]     multiplier,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   product,
   output logic [N-1:0]     arr_mcand,
   output logic             arr_xbit,
   output logic             arr_clr,
   input  logic             arr_pbit
);

   localparam int PW = 2 * N;
   localparam int CW = spm_cnt_w(PW);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  mplier_q;
   logic [PW-1:0] prod_q;
   logic [PW-1:0] col_q;
   logic [PW-1:0] mplier_ext;
   logic          accept;

   assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
   assign mplier_ext = {{N{mplier_q[N-1]}}, mplier_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         arr_mcand <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
      end else begin
         if (accept) begin
            arr_mcand <= multiplicand;
            mplier_q  <= multiplier;
         end
         case (state)
            S_IDLE: begin
               if (start) state <= S_CLEAR;
            end
            S_CLEAR: begin
               cnt   <= '0;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (cnt == CW'(PW - 1)) begin
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               prod_q <= col_q;
               state  <= start ? S_CLEAR : S_IDLE;
            end
         endcase
      end
   end

   spm_deser #(.W(PW)) u_deser (
      .clk      (clk),
      .rst      (rst),
      .shift_en (state == S_SHIFT),
      .din      (arr_pbit),
      .q        (col_q)
   );

   // The collect register already holds the full result during DONE; route it
   // straight out so product is valid in the same cycle as the done pulse.
   assign product  = (state == S_DONE) ? col_q : prod_q;
   assign busy     = (state == S_CLEAR) || (state == S_SHIFT);
   assign done     = (state == S_DONE);
   assign arr_clr  = (state == S_CLEAR);
   assign arr_xbit = (state == S_SHIFT) && mplier_ext[cnt];

endmodule

// File: tb/tb_spm_seq_ctrl.sv
module tb_spm_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  multiplicand = '0;
   logic [7:0]  multiplier = '0;
   logic        busy, done, arr_xbit, arr_clr, arr_pbit;
   logic [15:0] product;
   logic [7:0]  arr_mcand;

   int total = 0;
   int bad   = 0;
   int ndone = 0;
   logic [15:0] sb[$];

   spm_seq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .arr_mcand    (arr_mcand),
      .arr_xbit     (arr_xbit),
      .arr_clr      (arr_clr),
      .arr_pbit     (arr_pbit)
   );

   initial forever #5 clk = ~clk;

   // Behavioural serial array: remembers the multiplier bits seen since the
   // last clear; product bit k is bit k of A * (bits 0..k of the multiplier).
   logic [15:0] xs = '0;
   logic [4:0]  kidx = 5'd16;
   logic [15:0] xcur, mprod;

   always @(posedge clk) begin
      if (arr_clr) begin
         xs   <= '0;
         kidx <= 5'd0;
      end else if (kidx < 5'd16) begin
         xs[kidx[3:0]] <= arr_xbit;
         kidx          <= kidx + 5'd1;
      end
   end

   always_comb begin
      xcur     = xs | ({15'b0, arr_xbit} << kidx);
      mprod    = {{8{arr_mcand[7]}}, arr_mcand} * xcur;
      arr_pbit = (kidx < 5'd16) ? mprod[kidx[3:0]] : 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && done === 1'b1) begin
         ndone++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [15:0] e;
            e = sb.pop_front();
            chk("product", product, e);
         end
      end
   end

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] expv, input int gk);
      logic [15:0] ext;
      int nb;
      ext = {{8{b[7]}}, b};
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      sb.push_back(expv);
      @(negedge clk);
      start        = 1'b0;
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      chk("clr_after_accept", arr_clr, 1);
      chk("xbit_in_clear", arr_xbit, 0);
      nb = busy;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         nb += busy;
         chk("xbit", arr_xbit, ext[k]);
         chk("clr_in_shift", arr_clr, 0);
         chk("mcand_stable", arr_mcand, a);
         if (k == gk) begin
            start        = 1'b1;
            multiplicand = 8'h81;
            multiplier   = 8'h7e;
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      chk("done_latency18", done, 1);
      chk("busy_cycles17", nb, 17);
      chk("busy_in_done", busy, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("product_hold", product, expv);
   endtask

   initial begin
      int cyc;
      int d0;

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_clr", arr_clr, 0);
      chk("rst_xbit", arr_xbit, 0);
      chk("rst_product", product, 0);
      chk("rst_mcand", arr_mcand, 0);
      @(negedge clk);
      rst = 1'b1;

      run_op(8'd5,   8'd3,   16'h000F, -1);
      run_op(8'hFD,  8'd7,   16'hFFEB, -1);
      run_op(8'h80,  8'h80,  16'h4000, -1);
      run_op(8'h7F,  8'h80,  16'hC080, -1);
      // start pulsed mid-SHIFT with other operands must be ignored
      run_op(8'd100, 8'hCE,  16'hEC78, 3);

      // abort at SHIFT cycle 5
      @(negedge clk);
      multiplicand = 8'd9;
      multiplier   = 8'd9;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_product", product, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      d0 = ndone;
      repeat (25) @(negedge clk);
      chk("abort_no_done", ndone, d0);
      run_op(8'd6, 8'hFA, 16'hFFDC, -1);

      // back-to-back with start held high through DONE
      @(negedge clk);
      multiplicand = 8'd2;
      multiplier   = 8'd2;
      start        = 1'b1;
      sb.push_back(16'h0004);
      cyc = 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) break;
      end
      chk("b2b_first_latency", cyc, 18);
      multiplicand = 8'd0;
      multiplier   = 8'hFF;
      sb.push_back(16'h0000);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_clear", arr_clr, 1);
      cyc = 1;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) break;
      end
      chk("b2b_second_latency", cyc, 18);
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
